sobel_scan_controller: RTL and testbench

Sequencer for the Sobel edge-detection datapath. Walks the image over every interior center pixel, issues the nine 3x3 window reads to pixel memory, tags returned data with its window index, handshakes the filled window into the Sobel compute stage, and issues one result write per center. It replaces ad-hoc row/column increment logic with a single controlled raster scan.

---
 rtl/sobel_pkg.sv | 41 ++++
 rtl/sobel_coord_counter.sv | 66 ++++++
 rtl/sobel_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_sobel_scan_controller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared state encoding, geometry constants and window-offset helpers
// for the Sobel raster-scan controller.
package sobel_pkg;

   localparam int COORD_W  = 8;
   localparam int WIN_SIZE = 9;
   localparam int K_W      = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DRAIN     = 3'd2,
      HANDSHAKE = 3'd3,
      WRITE     = 3'd4
   } state_e;

   function automatic logic [1:0] win_row_off(input logic [K_W-1:0] k);
      case (k)
         4'd0, 4'd1, 4'd2: return 2'd0;
         4'd3, 4'd4, 4'd5: return 2'd1;
         4'd6, 4'd7, 4'd8: return 2'd2;
         default:          return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] win_col_off(input logic [K_W-1:0] k);
      case (k)
         4'd0, 4'd3, 4'd6: return 2'd0;
         4'd1, 4'd4, 4'd7: return 2'd1;
         4'd2, 4'd5, 4'd8: return 2'd2;
         default:          return 2'd0;
      endcase
   endfunction

   // Window address = center + offset - 1; centers are interior so this never wraps.
   function automatic logic [COORD_W-1:0] win_addr(input logic [COORD_W-1:0] center,
                                                   input logic [1:0]         off);
      return center + COORD_W'(off) - COORD_W'(1'b1);
   endfunction

endpackage

// File: rtl/sobel_coord_counter.sv
// Center-pixel register pair with column-first raster advance over the
// interior of the image and a flag for the final center.
module sobel_coord_counter
   import sobel_pkg::*;
#(
   parameter int IMG_ROWS = 128,
   parameter int IMG_COLS = 128
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               advance_i,
   output logic [COORD_W-1:0] row_o,
   output logic [COORD_W-1:0] col_o,
   output logic [COORD_W-1:0] nxt_row_o,
   output logic [COORD_W-1:0] nxt_col_o,
   output logic               last_o
);

   localparam logic [COORD_W-1:0] FIRST    = COORD_W'(1);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_ROWS - 2);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_COLS - 2);

   logic [COORD_W-1:0] row_q, col_q, row_d, col_d;
   logic               col_wrap_s;
   logic               row_wrap_s;

   // Next center in raster order; after the final center it wraps back to (1,1).
   always_comb begin
      col_wrap_s = (col_q == LAST_COL);
      row_wrap_s = (row_q == LAST_ROW);
      row_d      = row_q;
      col_d      = col_q;
      if (col_wrap_s) begin
         col_d = FIRST;
         if (row_wrap_s) begin
            row_d = FIRST;
         end else begin
            row_d = row_q + COORD_W'(1);
         end
      end else begin
         col_d = col_q + COORD_W'(1);
      end
   end

   // Center registers: clear to the first interior pixel, otherwise step on advance.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         row_q <= FIRST;
         col_q <= FIRST;
      end else if (clear_i) begin
         row_q <= FIRST;
         col_q <= FIRST;
      end else if (advance_i) begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_o     = row_q;
   assign col_o     = col_q;
   assign nxt_row_o = row_d;
   assign nxt_col_o = col_d;
   assign last_o    = col_wrap_s & row_wrap_s;

endmodule

// File: rtl/sobel_scan_controller.sv
// Raster-scan sequencer: nine window reads per interior center, window
// handshake to the Sobel stage, then one result write at the center.
module sobel_scan_controller
   import sobel_pkg::*;
#(
   parameter int IMG_ROWS = 128,
   parameter int IMG_COLS = 128
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               rd_en_o,
   output logic [COORD_W-1:0] rd_row_o,
   output logic [COORD_W-1:0] rd_col_o,
   output logic               win_load_o,
   output logic [K_W-1:0]     win_index_o,
   output logic               sobel_valid_o,
   input  logic               sobel_ready_i,
   output logic               wr_en_o,
   output logic [COORD_W-1:0] wr_row_o,
   output logic [COORD_W-1:0] wr_col_o
);

   localparam logic [K_W-1:0] K_LAST = K_W'(WIN_SIZE - 1);

   state_e             state_q;
   logic [K_W-1:0]     k_q, k_nxt_s;
   logic               busy_q, done_q, rd_en_q, win_load_q, valid_q, wr_en_q;
   logic [COORD_W-1:0] rd_row_q, rd_col_q, wr_row_q, wr_col_q;
   logic [K_W-1:0]     win_index_q;

   logic               clear_s, advance_s, last_s;
   logic [COORD_W-1:0] row_s, col_s, nxt_row_s, nxt_col_s;

   assign clear_s   = (state_q == IDLE) & start_i;
   assign advance_s = (state_q == WRITE);
   assign k_nxt_s   = k_q + K_W'(1);

   sobel_coord_counter #(
      .IMG_ROWS (IMG_ROWS),
      .IMG_COLS (IMG_COLS)
   ) u_coord (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_s),
      .advance_i (advance_s),
      .row_o     (row_s),
      .col_o     (col_s),
      .nxt_row_o (nxt_row_s),
      .nxt_col_o (nxt_col_s),
      .last_o    (last_s)
   );

   // Scan FSM; every output is loaded with its value for the state being entered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         k_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_row_q    <= '0;
         rd_col_q    <= '0;
         win_load_q  <= 1'b0;
         win_index_q <= '0;
         valid_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_row_q    <= '0;
         wr_col_q    <= '0;
      end else begin
         done_q      <= 1'b0;
         win_load_q  <= rd_en_q;
         win_index_q <= rd_en_q ? k_q : '0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  // First center is (1,1), so its first window read is (0,0).
                  state_q  <= FETCH;
                  k_q      <= '0;
                  busy_q   <= 1'b1;
                  rd_en_q  <= 1'b1;
                  rd_row_q <= '0;
                  rd_col_q <= '0;
               end else begin
                  state_q  <= IDLE;
               end
            end
            FETCH: begin
               if (k_q == K_LAST) begin
                  state_q  <= DRAIN;
                  k_q      <= '0;
                  rd_en_q  <= 1'b0;
                  rd_row_q <= '0;
                  rd_col_q <= '0;
               end else begin
                  k_q      <= k_nxt_s;
                  rd_row_q <= win_addr(row_s, win_row_off(k_nxt_s));
                  rd_col_q <= win_addr(col_s, win_col_off(k_nxt_s));
               end
            end
            DRAIN: begin
               state_q <= HANDSHAKE;
               valid_q <= 1'b1;
            end
            HANDSHAKE: begin
               if (sobel_ready_i) begin
                  state_q  <= WRITE;
                  valid_q  <= 1'b0;
                  wr_en_q  <= 1'b1;
                  wr_row_q <= row_s;
                  wr_col_q <= col_s;
               end else begin
                  state_q  <= HANDSHAKE;
               end
            end
            WRITE: begin
               wr_en_q  <= 1'b0;
               wr_row_q <= '0;
               wr_col_q <= '0;
               if (last_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q  <= FETCH;
                  k_q      <= '0;
                  rd_en_q  <= 1'b1;
                  rd_row_q <= win_addr(nxt_row_s, 2'd0);
                  rd_col_q <= win_addr(nxt_col_s, 2'd0);
               end
            end
            default: begin
               state_q  <= IDLE;
               k_q      <= '0;
               busy_q   <= 1'b0;
               rd_en_q  <= 1'b0;
               rd_row_q <= '0;
               rd_col_q <= '0;
               valid_q  <= 1'b0;
               wr_en_q  <= 1'b0;
               wr_row_q <= '0;
               wr_col_q <= '0;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign rd_en_o       = rd_en_q;
   assign rd_row_o      = rd_row_q;
   assign rd_col_o      = rd_col_q;
   assign win_load_o    = win_load_q;
   assign win_index_o   = win_index_q;
   assign sobel_valid_o = valid_q;
   assign wr_en_o       = wr_en_q;
   assign wr_row_o      = wr_row_q;
   assign wr_col_o      = wr_col_q;

endmodule

// File: tb/tb_sobel_scan_controller.sv
// Directed bench for sobel_scan_controller over several image shapes, with a
// read/write scoreboard filled from a reference raster walk.
module tb_sobel_scan_controller;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] c;
      logic [3:0] k;
   } ent_t;

   logic       clk;
   logic [4:0] rst_n_s, start_s, ready_s;
   logic [4:0] busy_s, done_s, rd_en_s, win_load_s, valid_s, wr_en_s;
   logic [7:0] rd_row_s [5];
   logic [7:0] rd_col_s [5];
   logic [7:0] wr_row_s [5];
   logic [7:0] wr_col_s [5];
   logic [3:0] win_idx_s [5];

   int   total = 0;
   int   bad   = 0;
   int   sel   = 0;
   ent_t rd_q [$];
   ent_t wr_q [$];

   int          cyc = 0;
   int          busy_cnt = 0, valid_cnt = 0, wr_cnt = 0, exp_gap = 0, last_wr_cyc = 0;
   logic        pend = 1'b0;
   logic [3:0]  pend_k = 4'd0;
   logic [15:0] last_wr = 16'd0, prev_wr = 16'd0;
   logic [7:0]  max_rd_row = 8'd0, max_rd_col = 8'd0;

   function automatic int rows_of(input int g);
      case (g)
         0: return 3;
         1: return 4;
         2: return 256;
         3: return 3;
         default: return 256;
      endcase
   endfunction

   function automatic int cols_of(input int g);
      case (g)
         0: return 3;
         1: return 4;
         2: return 256;
         3: return 256;
         default: return 3;
      endcase
   endfunction

   for (genvar g = 0; g < 5; g++) begin : g_dut
      sobel_scan_controller #(
         .IMG_ROWS (rows_of(g)),
         .IMG_COLS (cols_of(g))
      ) u_dut (
         .clk_i         (clk),
         .rst_ni        (rst_n_s[g]),
         .start_i       (start_s[g]),
         .busy_o        (busy_s[g]),
         .done_o        (done_s[g]),
         .rd_en_o       (rd_en_s[g]),
         .rd_row_o      (rd_row_s[g]),
         .rd_col_o      (rd_col_s[g]),
         .win_load_o    (win_load_s[g]),
         .win_index_o   (win_idx_s[g]),
         .sobel_valid_o (valid_s[g]),
         .sobel_ready_i (ready_s[g]),
         .wr_en_o       (wr_en_s[g]),
         .wr_row_o      (wr_row_s[g]),
         .wr_col_o      (wr_col_s[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference raster walk: nine reads then one write per interior center.
   task automatic push_frame(input int rows, input int cols, input int n);
      int r = 1;
      int c = 1;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 9; k++)
            rd_q.push_back('{r: 8'(r + k / 3 - 1), c: 8'(c + k % 3 - 1), k: 4'(k)});
         wr_q.push_back('{r: 8'(r), c: 8'(c), k: 4'd0});
         if (c == cols - 2) begin
            c = 1;
            r = r + 1;
         end else begin
            c = c + 1;
         end
      end
   endtask

   task automatic clear_stats();
      busy_cnt = 0; valid_cnt = 0; wr_cnt = 0;
      max_rd_row = 8'd0; max_rd_col = 8'd0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start_s[sel] = 1'b1;
      @(posedge clk); #1 start_s[sel] = 1'b0;
      check("first_rd_en", 32'(rd_en_s[sel]), 32'd1);
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done_s[sel] && n < budget);
   endtask

   // Scoreboard monitor on the falling edge for whichever instance is selected.
   always @(negedge clk) begin
      ent_t e;
      cyc++;
      if (!rst_n_s[sel]) begin
         pend = 1'b0;
      end else begin
         if (busy_s[sel])  busy_cnt++;
         if (valid_s[sel]) valid_cnt++;
         check("win_load", 32'(win_load_s[sel]), 32'(pend));
         if (pend) check("win_index", 32'(win_idx_s[sel]), 32'(pend_k));
         pend = 1'b0;
         if (rd_en_s[sel]) begin
            check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
               e = rd_q.pop_front();
               check("rd_row", 32'(rd_row_s[sel]), 32'(e.r));
               check("rd_col", 32'(rd_col_s[sel]), 32'(e.c));
               pend   = 1'b1;
               pend_k = e.k;
            end
            if (rd_row_s[sel] > max_rd_row) max_rd_row = rd_row_s[sel];
            if (rd_col_s[sel] > max_rd_col) max_rd_col = rd_col_s[sel];
         end
         if (wr_en_s[sel]) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               e = wr_q.pop_front();
               check("wr_row", 32'(wr_row_s[sel]), 32'(e.r));
               check("wr_col", 32'(wr_col_s[sel]), 32'(e.c));
            end
            if (wr_cnt > 0 && exp_gap != 0) check("wr_gap", 32'(cyc - last_wr_cyc), 32'(exp_gap));
            prev_wr     = last_wr;
            last_wr     = {wr_row_s[sel], wr_col_s[sel]};
            last_wr_cyc = cyc;
            wr_cnt++;
         end
      end
   end

   initial begin
      int n;
      logic [3:0] act;
      rst_n_s = 5'b0;
      start_s = 5'b0;
      ready_s = 5'b11111;

      // Reset state of every output.
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  32'(busy_s[0]),     32'd0);
      check("rst_done",  32'(done_s[0]),     32'd0);
      check("rst_rd_en", 32'(rd_en_s[0]),    32'd0);
      check("rst_wload", 32'(win_load_s[0]), 32'd0);
      check("rst_valid", 32'(valid_s[0]),    32'd0);
      check("rst_wr_en", 32'(wr_en_s[0]),    32'd0);
      check("rst_rd_rc", 32'({rd_row_s[0], rd_col_s[0]}), 32'd0);
      check("rst_wr_rc", 32'({wr_row_s[0], wr_col_s[0]}), 32'd0);
      rst_n_s = 5'b11111;

      // 3x3, ready high: single center, Done 12 cycles after first read.
      sel = 0; exp_gap = 0; clear_stats();
      push_frame(3, 3, 1);
      pulse_start();
      wait_done(40, n);
      check("3x3_done_lat", 32'(n), 32'd12);
      check("3x3_busy",     32'(busy_cnt), 32'd12);
      check("3x3_wr_cnt",   32'(wr_cnt), 32'd1);

      // Start in the Done cycle restarts, this time with backpressure.
      clear_stats();
      ready_s[0] = 1'b0;
      push_frame(3, 3, 1);
      start_s[0] = 1'b1;
      @(posedge clk); #1 start_s[0] = 1'b0;
      check("done_one_cycle", 32'(done_s[0]), 32'd0);
      check("restart_rd_en",  32'(rd_en_s[0]), 32'd1);
      n = 0;
      while (!valid_s[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("valid_latency", 32'(n), 32'd10);
      repeat (4) begin
         @(posedge clk); #1;
         check("valid_hold", 32'(valid_s[0]), 32'd1);
         check("no_wr_early", 32'(wr_en_s[0]), 32'd0);
      end
      @(posedge clk); #1 ready_s[0] = 1'b1;
      check("valid_hold6", 32'(valid_s[0]), 32'd1);
      @(posedge clk); #1;
      check("wr_after_hs",   32'(wr_en_s[0]), 32'd1);
      check("valid_dropped", 32'(valid_s[0]), 32'd0);
      check("valid_cycles",  32'(valid_cnt), 32'd6);
      wait_done(10, n);
      check("bp_done_lat", 32'(n), 32'd1);

      // 4x4, ready high: four writes 12 cycles apart, 48 busy cycles.
      sel = 1; exp_gap = 12; clear_stats();
      push_frame(4, 4, 4);
      pulse_start();
      wait_done(100, n);
      check("4x4_done_lat", 32'(n), 32'd48);
      check("4x4_busy",     32'(busy_cnt), 32'd48);
      check("4x4_wr_cnt",   32'(wr_cnt), 32'd4);
      @(posedge clk); #1;
      check("4x4_done_pulse", 32'(done_s[1]), 32'd0);

      // Start pulsed again mid-FETCH is ignored.
      clear_stats();
      push_frame(4, 4, 4);
      pulse_start();
      repeat (3) @(posedge clk);
      #1 start_s[1] = 1'b1;
      @(posedge clk); #1 start_s[1] = 1'b0;
      wait_done(100, n);
      check("glitch_done_lat", 32'(n), 32'd44);
      check("glitch_wr_cnt",   32'(wr_cnt), 32'd4);

      // Asynchronous reset during FETCH k=4.
      clear_stats();
      push_frame(4, 4, 4);
      pulse_start();
      repeat (4) @(posedge clk);
      #3 rst_n_s[1] = 1'b0;
      #1;
      check("arst_outs", 32'({busy_s[1], done_s[1], rd_en_s[1], win_load_s[1], valid_s[1], wr_en_s[1]}), 32'd0);
      check("arst_addr", 32'({rd_row_s[1], rd_col_s[1], win_idx_s[1]}), 32'd0);
      rd_q.delete();
      wr_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n_s[1] = 1'b1;
      act = 4'd0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         act = act | {done_s[1], rd_en_s[1], wr_en_s[1], busy_s[1]};
      end
      check("arst_quiet", 32'(act), 32'd0);
      clear_stats();
      push_frame(4, 4, 4);
      pulse_start();
      wait_done(100, n);
      check("post_rst_done_lat", 32'(n), 32'd48);
      check("post_rst_wr_cnt",   32'(wr_cnt), 32'd4);

      // 3x256: one row of 254 centers, reads reach column 255.
      sel = 3; clear_stats();
      push_frame(3, 256, 254);
      pulse_start();
      wait_done(4000, n);
      check("wide_done_lat", 32'(n), 32'd3048);
      check("wide_last_wr",  32'(last_wr), 32'({8'd1, 8'd254}));
      check("wide_max_col",  32'(max_rd_col), 32'd255);

      // 256x3: one column of 254 centers, last write at (254,1).
      sel = 4; clear_stats();
      push_frame(256, 3, 254);
      pulse_start();
      wait_done(4000, n);
      check("tall_done_lat", 32'(n), 32'd3048);
      check("tall_last_wr",  32'(last_wr), 32'({8'd254, 8'd1}));
      check("tall_max_row",  32'(max_rd_row), 32'd255);

      // 256x256: first row plus the wrap from column 254 to row 2, column 1.
      sel = 2; clear_stats();
      push_frame(256, 256, 256);
      pulse_start();
      n = 0;
      while (wr_cnt < 255 && n < 3200) begin
         @(posedge clk); #1;
         n++;
      end
      check("big_wr_cnt",  32'(wr_cnt), 32'd255);
      check("big_prev_wr", 32'(prev_wr), 32'({8'd1, 8'd254}));
      check("big_last_wr", 32'(last_wr), 32'({8'd2, 8'd1}));
      check("big_max_col", 32'(max_rd_col), 32'd255);
      rst_n_s[2] = 1'b0;
      @(posedge clk); #1;
      rd_q.delete();
      wr_q.delete();
      rst_n_s[2] = 1'b1;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
